// File: rtl/act_quant_relu.sv
// act_quant_relu -- multi-lane requantisation and activation stage.
//
// Sits between the conv accumulator and the pooling/line-buffer stage. Each of
// the CH lanes gets a rounding arithmetic right shift, then one of four
// activations, then signed saturation to OUT_W. The sync/valid strobes and the
// h/v position counters are delayed alongside the data, so every output has a
// latency of exactly two clocks.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   cfg_mode              0 saturate, 1 ReLU, 2 ReLU clamped to cfg_cap, 3 leaky (neg>>>3)
//   cfg_shift             requant right shift 0..31
//   cfg_cap               clamp ceiling for mode 2, unsigned
//   conv_h_cnt/v_cnt      input position counters
//   pre_vsync, pre_href   input frame sync / data valid
//   pre_data              CH signed IN_W lanes, lane k at [k*IN_W +: IN_W]
//   act_h_cnt/v_cnt       delayed position counters
//   act_vsync, act_href   delayed frame sync / data valid
//   act_data              CH signed OUT_W lanes, zero while act_href is low
//   sat_cnt               saturated lane-samples in the previous frame
//                         (present only when ACT_SAT_CNT_EN is defined)
//
// Build option: define ACT_SAT_CNT_EN to add the saturation event counter.

module act_quant_relu #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int CH    = 4,
  parameter int CNT_W = 7,
  parameter int SAT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          cfg_mode,
  input  logic [4:0]          cfg_shift,
  input  logic [OUT_W-1:0]    cfg_cap,
  input  logic [CNT_W-1:0]    conv_h_cnt,
  input  logic [CNT_W-1:0]    conv_v_cnt,
  input  logic                pre_vsync,
  input  logic                pre_href,
  input  logic [CH*IN_W-1:0]  pre_data,
  output logic [CNT_W-1:0]    act_h_cnt,
  output logic [CNT_W-1:0]    act_v_cnt,
  output logic                act_vsync,
  output logic                act_href,
`ifdef ACT_SAT_CNT_EN
  output logic [SAT_W-1:0]    sat_cnt,
`endif
  output logic [CH*OUT_W-1:0] act_data
);

  typedef enum logic [1:0] {
    MODE_SAT   = 2'd0,
    MODE_RELU  = 2'd1,
    MODE_CAP   = 2'd2,
    MODE_LEAKY = 2'd3
  } mode_e;

  // One guard bit so that max-positive plus the rounding constant cannot wrap.
  localparam int RW = IN_W + 1;
  localparam logic signed [RW-1:0] OMAX   = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] OMIN   = ~OMAX;
  localparam logic [OUT_W-1:0]     OMAX_O = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]     OMIN_O = ~OMAX_O;

  // Config shadow and sync-edge detection
  logic              init_q, init_d;
  logic              vs_in_q, vs_in_d;
  mode_e             mode_sh_q, mode_sh_d;
  logic [4:0]        shift_sh_q, shift_sh_d;
  logic [OUT_W-1:0]  cap_sh_q, cap_sh_d;
  logic              take_cfg;

  // Stage 1: shifted lanes plus the config that travels with them
  logic signed [RW-1:0] s1_r_q [CH];
  logic signed [RW-1:0] s1_r_d [CH];
  mode_e                s1_mode_q, s1_mode_d;
  logic [OUT_W-1:0]     s1_capc_q, s1_capc_d;
  logic                 s1_href_q, s1_href_d;
  logic                 s1_vsync_q, s1_vsync_d;
  logic [CNT_W-1:0]     s1_h_q, s1_h_d, s1_v_q, s1_v_d;
  logic signed [RW-1:0] rnd, x;

  // Stage 2: outputs
  logic [CH*OUT_W-1:0]  act_data_q, act_data_d;
  logic                 act_href_q, act_href_d;
  logic                 act_vsync_q, act_vsync_d;
  logic [CNT_W-1:0]     act_h_q, act_h_d, act_v_q, act_v_d;
  logic signed [RW-1:0] r, rl;
  logic [OUT_W-1:0]     sat_r, sat_rl, y;
  logic [CH-1:0]        r_hi, r_lo, rl_lo, r_neg;

  // Stage 1: the shadow is refreshed on a vsync rise (or the first clock out of
  // reset) and the refreshed value already applies to that same beat.
  always_comb begin
    take_cfg   = init_q | (pre_vsync & ~vs_in_q);
    init_d     = 1'b0;
    vs_in_d    = pre_vsync;
    mode_sh_d  = take_cfg ? mode_e'(cfg_mode) : mode_sh_q;
    shift_sh_d = take_cfg ? cfg_shift         : shift_sh_q;
    cap_sh_d   = take_cfg ? cfg_cap           : cap_sh_q;

    rnd = (shift_sh_d == 5'd0) ? '0 : (RW'(1) << (shift_sh_d - 5'd1));
    x   = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      x         = RW'($signed(pre_data[k*IN_W +: IN_W]));
      s1_r_d[k] = (x + rnd) >>> shift_sh_d;
    end

    s1_mode_d  = mode_sh_d;
    s1_capc_d  = (cap_sh_d > OMAX_O) ? OMAX_O : cap_sh_d;
    s1_href_d  = pre_href;
    s1_vsync_d = pre_vsync;
    s1_h_d     = conv_h_cnt;
    s1_v_d     = conv_v_cnt;
  end

  // Stage 2: activation and saturation
  always_comb begin
    act_data_d = '0;
    r_hi  = '0;
    r_lo  = '0;
    rl_lo = '0;
    r_neg = '0;
    r      = '0;
    rl     = '0;
    sat_r  = '0;
    sat_rl = '0;
    y      = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      r        = s1_r_q[k];
      rl       = r >>> 3;
      r_neg[k] = r[RW-1];
      r_hi[k]  = r > OMAX;
      r_lo[k]  = r < OMIN;
      rl_lo[k] = rl < OMIN;
      sat_r    = r_hi[k] ? OMAX_O : (r_lo[k] ? OMIN_O : r[OUT_W-1:0]);
      sat_rl   = rl_lo[k] ? OMIN_O : rl[OUT_W-1:0];
      y        = sat_r;
      unique case (s1_mode_q)
        MODE_SAT:   y = sat_r;
        MODE_RELU:  y = r_neg[k] ? '0 : sat_r;
        // sat_r is non-negative here, so an unsigned compare against the cap is valid.
        MODE_CAP:   y = r_neg[k] ? '0 : ((sat_r > s1_capc_q) ? s1_capc_q : sat_r);
        MODE_LEAKY: y = r_neg[k] ? sat_rl : sat_r;
      endcase
      act_data_d[k*OUT_W +: OUT_W] = s1_href_q ? y : '0;
    end
    act_href_d  = s1_href_q;
    act_vsync_d = s1_vsync_q;
    act_h_d     = s1_h_q;
    act_v_d     = s1_v_q;
  end

`ifdef ACT_SAT_CNT_EN
  // Saturation events count only clipping by sat(); ReLU zeroing and the cap
  // do not count.
  logic [CH-1:0]    lane_sat;
  logic [SAT_W-1:0] beat_sat;
  logic [SAT_W:0]   acc_sum;
  logic [SAT_W-1:0] sat_acc_q, sat_acc_d, sat_cnt_q, sat_cnt_d;

  always_comb begin
    beat_sat = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      unique case (s1_mode_q)
        MODE_SAT:   lane_sat[k] = r_hi[k] | r_lo[k];
        MODE_LEAKY: lane_sat[k] = r_neg[k] ? rl_lo[k] : r_hi[k];
        default:    lane_sat[k] = r_hi[k];
      endcase
      beat_sat = beat_sat + SAT_W'(lane_sat[k] & s1_href_q);
    end
    acc_sum = {1'b0, sat_acc_q} + {1'b0, beat_sat};
    if (s1_vsync_q && !act_vsync_q) begin
      sat_cnt_d = sat_acc_q;
      sat_acc_d = beat_sat;
    end else begin
      sat_cnt_d = sat_cnt_q;
      sat_acc_d = acc_sum[SAT_W] ? '1 : acc_sum[SAT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_acc_q <= '0;
      sat_cnt_q <= '0;
    end else begin
      sat_acc_q <= sat_acc_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt = sat_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q      <= 1'b1;
      vs_in_q     <= 1'b0;
      mode_sh_q   <= MODE_RELU;
      shift_sh_q  <= '0;
      cap_sh_q    <= OMAX_O;
      for (int unsigned k = 0; k < CH; k++) s1_r_q[k] <= '0;
      s1_mode_q   <= MODE_RELU;
      s1_capc_q   <= '0;
      s1_href_q   <= 1'b0;
      s1_vsync_q  <= 1'b0;
      s1_h_q      <= '0;
      s1_v_q      <= '0;
      act_data_q  <= '0;
      act_href_q  <= 1'b0;
      act_vsync_q <= 1'b0;
      act_h_q     <= '0;
      act_v_q     <= '0;
    end else begin
      init_q      <= init_d;
      vs_in_q     <= vs_in_d;
      mode_sh_q   <= mode_sh_d;
      shift_sh_q  <= shift_sh_d;
      cap_sh_q    <= cap_sh_d;
      for (int unsigned k = 0; k < CH; k++) s1_r_q[k] <= s1_r_d[k];
      s1_mode_q   <= s1_mode_d;
      s1_capc_q   <= s1_capc_d;
      s1_href_q   <= s1_href_d;
      s1_vsync_q  <= s1_vsync_d;
      s1_h_q      <= s1_h_d;
      s1_v_q      <= s1_v_d;
      act_data_q  <= act_data_d;
      act_href_q  <= act_href_d;
      act_vsync_q <= act_vsync_d;
      act_h_q     <= act_h_d;
      act_v_q     <= act_v_d;
    end
  end

  assign act_data  = act_data_q;
  assign act_href  = act_href_q;
  assign act_vsync = act_vsync_q;
  assign act_h_cnt = act_h_q;
  assign act_v_cnt = act_v_q;

endmodule
